// File: rtl/seu_counter.sv
// ---------------------------------------------------------------------------
// seu_counter: two-flop synchronizer, symmetric glitch filter and saturating
// rising-edge counter for an asynchronous SEU pulse input.
// Optional macro SEU_TIMESTAMP_EN adds a free-running timestamp and last_ts.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seu_counter #(
  parameter int CTR_W    = 32,
  parameter int FILT_LEN = 4
`ifdef SEU_TIMESTAMP_EN
  ,
  parameter int TS_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SEUin,
  input  logic             clr,
  output logic [CTR_W-1:0] CTRout,
  output logic             SEU_filt
`ifdef SEU_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  last_ts
`endif
);

  localparam int            c_cnt_w    = $clog2(FILT_LEN + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_LEN - 1);

  logic               r_seu_presyn1;
  logic               r_seu_syn;
  logic               r_glitch_filt;
  logic [c_cnt_w-1:0] r_filt_cnt;
  logic [CTR_W-1:0]   r_ctr;

  logic w_mismatch;
  logic w_accept;
  logic w_rise;
  logic w_ctr_max;

  assign w_mismatch = r_seu_syn ^ r_glitch_filt;
  assign w_accept   = w_mismatch && (r_filt_cnt == c_cnt_last);
  // Accepting a mismatch with the synchronized level high means a 0->1 change.
  assign w_rise     = w_accept && r_seu_syn;
  assign w_ctr_max  = &r_ctr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seu_presyn1 <= 1'b0;
      r_seu_syn     <= 1'b0;
      r_glitch_filt <= 1'b0;
      r_filt_cnt    <= '0;
      r_ctr         <= '0;
    end else begin
      r_seu_presyn1 <= SEUin;
      r_seu_syn     <= r_seu_presyn1;

      if (!w_mismatch) begin
        r_filt_cnt <= '0;
      end else if (w_accept) begin
        r_glitch_filt <= r_seu_syn;
        r_filt_cnt    <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end

      // Clear takes precedence over a coincident count; that event is dropped.
      if (clr) begin
        r_ctr <= '0;
      end else if (w_rise && !w_ctr_max) begin
        r_ctr <= r_ctr + 1'b1;
      end
    end
  end

  assign CTRout   = r_ctr;
  assign SEU_filt = r_glitch_filt;

`ifdef SEU_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts_cnt;
  logic [TS_W-1:0] r_last_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts_cnt  <= '0;
      r_last_ts <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 1'b1;
      if (clr) begin
        r_last_ts <= '0;
      end else if (w_rise) begin
        r_last_ts <= r_ts_cnt;
      end
    end
  end

  assign last_ts = r_last_ts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seu_counter.sv
// ---------------------------------------------------------------------------
// tb_seu_counter: randomized and directed checks of seu_counter against a
// queue-based reference model (main instance plus a 3-bit saturating copy).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seu_counter;

  localparam int FILT_LEN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SEUin = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] CTRout;
  logic        SEU_filt;
  logic [2:0]  CTRout_s;
  logic        SEU_filt_s;
`ifdef SEU_TIMESTAMP_EN
  logic [31:0] last_ts;
  logic [31:0] last_ts_s;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seu_counter #(.CTR_W(32), .FILT_LEN(FILT_LEN)) dut (
    .clk(clk), .rst(rst), .SEUin(SEUin), .clr(clr),
    .CTRout(CTRout), .SEU_filt(SEU_filt)
`ifdef SEU_TIMESTAMP_EN
    , .last_ts(last_ts)
`endif
  );

  seu_counter #(.CTR_W(3), .FILT_LEN(FILT_LEN)) dut_sat (
    .clk(clk), .rst(rst), .SEUin(SEUin), .clr(clr),
    .CTRout(CTRout_s), .SEU_filt(SEU_filt_s)
`ifdef SEU_TIMESTAMP_EN
    , .last_ts(last_ts_s)
`endif
  );

  // Reference model: the filter sees the input from two edges earlier and
  // flips its level once the last FILT_LEN seen samples all disagree with it.
  bit          in_q[$];
  bit          syn_q[$];
  bit          m_filt = 1'b0;
  logic [31:0] m_ctr = '0;
  int          m_ctr_s = 0;
  logic [31:0] m_ts = '0;
  logic [31:0] m_last_ts = '0;

  always @(posedge clk) begin
    bit seen;
    bit acc;
    if (rst) begin
      in_q.delete();
      syn_q.delete();
      m_filt    = 1'b0;
      m_ctr     = '0;
      m_ctr_s   = 0;
      m_ts      = '0;
      m_last_ts = '0;
    end else begin
      in_q.push_back(SEUin);
      seen = (in_q.size() >= 3) ? in_q[in_q.size()-3] : 1'b0;
      syn_q.push_back(seen);
      acc = 1'b0;
      if (syn_q.size() >= FILT_LEN) begin
        acc = 1'b1;
        for (int i = 0; i < FILT_LEN; i++)
          if (syn_q[syn_q.size()-1-i] == m_filt) acc = 1'b0;
      end
      if (clr) begin
        m_ctr     = '0;
        m_ctr_s   = 0;
        m_last_ts = '0;
      end else if (acc && !m_filt) begin
        if (m_ctr != 32'hFFFF_FFFF) m_ctr = m_ctr + 1;
        if (m_ctr_s < 7) m_ctr_s = m_ctr_s + 1;
        m_last_ts = m_ts;
      end
      if (acc) m_filt = ~m_filt;
      m_ts = m_ts + 1;
      while (in_q.size() > 8) in_q.pop_front();
      while (syn_q.size() > 8) syn_q.pop_front();
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SEUin = i[0];
      @(negedge clk);
      n_checks++;
      if (CTRout !== 32'd0 || SEU_filt !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_during: CTRout=%0h SEU_filt=%b, required 0/0", CTRout, SEU_filt);
      end
    end
    rst = 1'b0;
    SEUin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (CTRout !== 32'd0 || SEU_filt !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_after: CTRout=%0h SEU_filt=%b, required 0/0", CTRout, SEU_filt);
      end
    end
  endtask

  task automatic test_single_pulse();
    // Input first sampled at edge N; count appears at edge N+FILT_LEN+1.
    SEUin = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == FILT_LEN) begin
        n_checks++;
        if (CTRout !== 32'd0) begin
          n_errors++;
          $display("FAIL pulse_early: CTRout=%0d, required 0", CTRout);
        end
      end
      if (k == FILT_LEN + 1) begin
        n_checks++;
        if (CTRout !== 32'd1) begin
          n_errors++;
          $display("FAIL pulse_latency: CTRout=%0d, required 1", CTRout);
        end
      end
    end
    SEUin = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (CTRout !== 32'd1 || SEU_filt !== 1'b0) begin
      n_errors++;
      $display("FAIL pulse_after: CTRout=%0d SEU_filt=%b, required 1/0", CTRout, SEU_filt);
    end
  endtask

  task automatic test_glitch_gap();
    int seg_len[6] = '{3, 3, 10, 2, 10, 2};
    int falls = 0;
    logic prev = 1'b0;
    for (int s = 0; s < 6; s++) begin
      SEUin = (s % 2 == 0);
      for (int c = 0; c < seg_len[s]; c++) begin
        @(negedge clk);
        n_checks++;
        if (CTRout !== m_ctr || SEU_filt !== m_filt) begin
          n_errors++;
          $display("FAIL glitch_track: CTRout=%0d SEU_filt=%b, required %0d/%b", CTRout, SEU_filt, m_ctr, m_filt);
        end
        if (prev && !SEU_filt) falls++;
        prev = SEU_filt;
      end
    end
    n_checks++;
    if (falls != 0) begin
      n_errors++;
      $display("FAIL gap_no_drop: SEU_filt fell %0d times, required 0", falls);
    end
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (CTRout !== 32'd2) begin
      n_errors++;
      $display("FAIL glitch_final: CTRout=%0d, required 2", CTRout);
    end
  endtask

  task automatic test_boundary();
    SEUin = 1'b1;
    repeat (FILT_LEN) @(negedge clk);
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (CTRout !== 32'd3) begin
      n_errors++;
      $display("FAIL width_min_counted: CTRout=%0d, required 3", CTRout);
    end
    SEUin = 1'b1;
    repeat (FILT_LEN - 1) @(negedge clk);
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (CTRout !== 32'd3) begin
      n_errors++;
      $display("FAIL width_short_rejected: CTRout=%0d, required 3", CTRout);
    end
  endtask

  task automatic test_clear();
    SEUin = 1'b1;
    repeat (FILT_LEN + 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (CTRout !== 32'd0 || SEU_filt !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_on_event: CTRout=%0d SEU_filt=%b, required 0/1", CTRout, SEU_filt);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (CTRout !== 32'd0) begin
      n_errors++;
      $display("FAIL held_high_once: CTRout=%0d, required 0", CTRout);
    end
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 9; p++) begin
      SEUin = 1'b1;
      repeat (5) @(negedge clk);
      SEUin = 1'b0;
      repeat (8) @(negedge clk);
    end
    n_checks++;
    if (CTRout_s !== 3'd7) begin
      n_errors++;
      $display("FAIL saturate: CTRout_s=%0d, required 7", CTRout_s);
    end
    n_checks++;
    if (CTRout !== 32'd9) begin
      n_errors++;
      $display("FAIL sat_wide_count: CTRout=%0d, required 9", CTRout);
    end
  endtask

  task automatic test_random();
    int run;
    for (int r = 0; r < 120; r++) begin
      SEUin = $urandom_range(1, 0);
      run = $urandom_range(8, 1);
      for (int c = 0; c < run; c++) begin
        clr = ($urandom_range(49, 0) == 0);
        @(negedge clk);
        n_checks++;
        if (CTRout !== m_ctr || SEU_filt !== m_filt || CTRout_s !== 3'(m_ctr_s)) begin
          n_errors++;
          $display("FAIL random: CTRout=%0d SEU_filt=%b CTRout_s=%0d, required %0d/%b/%0d",
                   CTRout, SEU_filt, CTRout_s, m_ctr, m_filt, m_ctr_s);
        end
`ifdef SEU_TIMESTAMP_EN
        n_checks++;
        if (last_ts !== m_last_ts) begin
          n_errors++;
          $display("FAIL random_ts: last_ts=%0d, required %0d", last_ts, m_last_ts);
        end
`endif
      end
    end
    clr = 1'b0;
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
  endtask

`ifdef SEU_TIMESTAMP_EN
  task automatic test_timestamp();
    // Edge 0 is the first edge with rst low; the event is first sampled at edge 20.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    SEUin = 1'b1;
    repeat (FILT_LEN + 2) @(negedge clk);
    n_checks++;
    if (last_ts !== 32'd25) begin
      n_errors++;
      $display("FAIL ts_capture: last_ts=%0d, required 25", last_ts);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (last_ts !== 32'd0) begin
      n_errors++;
      $display("FAIL ts_clear: last_ts=%0d, required 0", last_ts);
    end
    SEUin = 1'b0;
    repeat (12) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single_pulse();
    test_glitch_gap();
    test_boundary();
    test_clear();
    test_saturation();
    test_random();
`ifdef SEU_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
